// File: rtl/l1_dcache_tlc_if.sv
// CPU request port plus the five TileLink-C channels of the L1 data cache.
// Signal suffixes are from the cache's point of view.
interface l1_dcache_tlc_if;
  logic        req_i, we_i;
  logic [7:0]  be_i;
  logic [63:0] addr_i, wdata_i;
  logic        gnt_o, rvalid_o;
  logic [63:0] rdata_o;

  logic        tl_a_valid_o, tl_a_ready_i;
  logic [2:0]  tl_a_opcode_o, tl_a_param_o;
  logic [3:0]  tl_a_size_o, tl_a_source_o;
  logic [63:0] tl_a_address_o, tl_a_data_o;
  logic [7:0]  tl_a_mask_o;
  logic        tl_a_corrupt_o;

  logic        tl_b_valid_i, tl_b_ready_o;
  logic [2:0]  tl_b_opcode_i, tl_b_param_i;
  logic [3:0]  tl_b_size_i, tl_b_source_i;
  logic [63:0] tl_b_address_i, tl_b_data_i;
  logic [7:0]  tl_b_mask_i;
  logic        tl_b_corrupt_i;

  logic        tl_c_valid_o, tl_c_ready_i;
  logic [2:0]  tl_c_opcode_o, tl_c_param_o;
  logic [3:0]  tl_c_size_o, tl_c_source_o;
  logic [63:0] tl_c_address_o, tl_c_data_o;
  logic        tl_c_corrupt_o;

  logic        tl_d_valid_i, tl_d_ready_o;
  logic [2:0]  tl_d_opcode_i;
  logic [1:0]  tl_d_param_i;
  logic [3:0]  tl_d_size_i, tl_d_source_i, tl_d_sink_i;
  logic        tl_d_denied_i, tl_d_corrupt_i;
  logic [63:0] tl_d_data_i;

  logic        tl_e_valid_o, tl_e_ready_i;
  logic [3:0]  tl_e_sink_o;

  modport master (
    input  req_i, we_i, be_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o,
    output tl_a_valid_o, tl_a_opcode_o, tl_a_param_o, tl_a_size_o, tl_a_source_o,
           tl_a_address_o, tl_a_mask_o, tl_a_data_o, tl_a_corrupt_o,
    input  tl_a_ready_i,
    input  tl_b_valid_i, tl_b_opcode_i, tl_b_param_i, tl_b_size_i, tl_b_source_i,
           tl_b_address_i, tl_b_mask_i, tl_b_data_i, tl_b_corrupt_i,
    output tl_b_ready_o,
    output tl_c_valid_o, tl_c_opcode_o, tl_c_param_o, tl_c_size_o, tl_c_source_o,
           tl_c_address_o, tl_c_data_o, tl_c_corrupt_o,
    input  tl_c_ready_i,
    input  tl_d_valid_i, tl_d_opcode_i, tl_d_param_i, tl_d_size_i, tl_d_source_i,
           tl_d_sink_i, tl_d_denied_i, tl_d_data_i, tl_d_corrupt_i,
    output tl_d_ready_o,
    output tl_e_valid_o, tl_e_sink_o,
    input  tl_e_ready_i
  );

  modport slave (
    output req_i, we_i, be_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o,
    input  tl_a_valid_o, tl_a_opcode_o, tl_a_param_o, tl_a_size_o, tl_a_source_o,
           tl_a_address_o, tl_a_mask_o, tl_a_data_o, tl_a_corrupt_o,
    output tl_a_ready_i,
    output tl_b_valid_i, tl_b_opcode_i, tl_b_param_i, tl_b_size_i, tl_b_source_i,
           tl_b_address_i, tl_b_mask_i, tl_b_data_i, tl_b_corrupt_i,
    input  tl_b_ready_o,
    input  tl_c_valid_o, tl_c_opcode_o, tl_c_param_o, tl_c_size_o, tl_c_source_o,
           tl_c_address_o, tl_c_data_o, tl_c_corrupt_o,
    output tl_c_ready_i,
    output tl_d_valid_i, tl_d_opcode_i, tl_d_param_i, tl_d_size_i, tl_d_source_i,
           tl_d_sink_i, tl_d_denied_i, tl_d_data_i, tl_d_corrupt_i,
    input  tl_d_ready_o,
    input  tl_e_valid_o, tl_e_sink_o,
    output tl_e_ready_i
  );
endinterface

// File: rtl/l1_dcache_tlc.sv
// Write-back, write-allocate, direct-mapped L1 data cache acting as a TileLink-C client.
// One outstanding CPU request; probes are served only from IDLE.
module l1_dcache_tlc #(
  parameter int         SETS      = 64,
  parameter logic [3:0] SOURCE_ID = 4'd0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic invalidate_all_i,
  l1_dcache_tlc_if.master bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 64 - 6 - IDX_W;

  localparam logic [3:0] S_IDLE = 4'd0, S_LOOKUP = 4'd1, S_REL = 4'd2, S_REL_ACK = 4'd3,
                         S_ACQ  = 4'd4, S_GRANT  = 4'd5, S_GACK = 4'd6, S_RESP = 4'd7,
                         S_PROBE = 4'd8;

  localparam logic [2:0] A_ACQUIRE_BLOCK = 3'd6;
  localparam logic [2:0] C_PROBE_ACK = 3'd4, C_PROBE_ACK_DATA = 3'd5;
  localparam logic [2:0] C_RELEASE = 3'd6, C_RELEASE_DATA = 3'd7;
  localparam logic [2:0] NTOB = 3'd0, NTOT = 3'd1, BTOT = 3'd2;
  localparam logic [2:0] TTON = 3'd1, BTON = 3'd2, NTON = 3'd5;

  logic [3:0]        state_q, state_d;
  logic [2:0]        beat_q, beat_d;
  logic [2:0]        acq_param_q, acq_param_d;
  logic [3:0]        sink_q, sink_d;
  logic [SETS-1:0]   valid_q, valid_d, dirty_q, dirty_d, perm_q, perm_d;

  logic              req_we_q;
  logic [7:0]        req_be_q;
  logic [63:0]       req_addr_q, req_wdata_q, prb_addr_q;

  logic [63:0]       data_mem [SETS*8];
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic              mem_we, tag_we;
  logic [IDX_W+2:0]  mem_waddr;
  logic [63:0]       mem_wdata;

  function automatic logic [63:0] merge_bytes(input logic [63:0] old_w, input logic [63:0] new_w,
                                              input logic [7:0] be);
    logic [63:0] res;
    res = old_w;
    for (int b = 0; b < 8; b++) if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    return res;
  endfunction

  // A probe works on its own address; every other state works on the latched request.
  logic              is_probe;
  logic [63:0]       cur_addr;
  logic [IDX_W-1:0]  cur_idx;
  logic [TAG_W-1:0]  cur_tag;
  logic [2:0]        req_word;
  logic              line_hit;
  logic [63:0]       rd_word, rd_beat, victim_addr;
  logic [2:0]        c_opcode, c_param;
  logic              c_last;

  assign is_probe    = (state_q == S_PROBE);
  assign cur_addr    = is_probe ? prb_addr_q : req_addr_q;
  assign cur_idx     = cur_addr[6 +: IDX_W];
  assign cur_tag     = cur_addr[63 -: TAG_W];
  assign req_word    = req_addr_q[5:3];
  assign line_hit    = valid_q[cur_idx] && (tag_mem[cur_idx] == cur_tag);
  assign rd_word     = data_mem[{cur_idx, req_word}];
  assign rd_beat     = data_mem[{cur_idx, beat_q}];
  assign victim_addr = {tag_mem[cur_idx], cur_idx, 6'b0};
  assign c_opcode    = is_probe ? ((line_hit && dirty_q[cur_idx]) ? C_PROBE_ACK_DATA : C_PROBE_ACK)
                                : (dirty_q[cur_idx] ? C_RELEASE_DATA : C_RELEASE);
  assign c_param     = (is_probe && !line_hit) ? NTON : (perm_q[cur_idx] ? TTON : BTON);
  assign c_last      = !c_opcode[0] || (beat_q == 3'd7);

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d     = state_q;
    beat_d      = beat_q;
    acq_param_d = acq_param_q;
    sink_d      = sink_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    perm_d      = perm_q;
    mem_we      = 1'b0;
    mem_waddr   = {cur_idx, req_word};
    mem_wdata   = merge_bytes(rd_word, req_wdata_q, req_be_q);
    tag_we      = 1'b0;

    bus.gnt_o          = 1'b0;
    bus.rvalid_o       = 1'b0;
    bus.rdata_o        = '0;
    bus.tl_a_valid_o   = 1'b0;
    bus.tl_a_opcode_o  = '0;
    bus.tl_a_param_o   = '0;
    bus.tl_a_size_o    = '0;
    bus.tl_a_source_o  = SOURCE_ID;
    bus.tl_a_address_o = '0;
    bus.tl_a_mask_o    = '0;
    bus.tl_a_data_o    = '0;
    bus.tl_a_corrupt_o = 1'b0;
    bus.tl_b_ready_o   = 1'b0;
    bus.tl_c_valid_o   = 1'b0;
    bus.tl_c_opcode_o  = '0;
    bus.tl_c_param_o   = '0;
    bus.tl_c_size_o    = '0;
    bus.tl_c_source_o  = SOURCE_ID;
    bus.tl_c_address_o = '0;
    bus.tl_c_data_o    = '0;
    bus.tl_c_corrupt_o = 1'b0;
    bus.tl_d_ready_o   = 1'b0;
    bus.tl_e_valid_o   = 1'b0;
    bus.tl_e_sink_o    = '0;

    case (state_q)
      S_IDLE: begin
        bus.tl_b_ready_o = !rst_i;
        if (invalidate_all_i) begin
          valid_d = '0;
          dirty_d = '0;
          perm_d  = '0;
        end
        if (bus.tl_b_valid_i) begin
          state_d = S_PROBE;
          beat_d  = '0;
        end else if (bus.req_i) begin
          bus.gnt_o = !rst_i;
          state_d   = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (line_hit && (!req_we_q || perm_q[cur_idx])) begin
          bus.rvalid_o = 1'b1;
          bus.rdata_o  = rd_word;
          state_d      = S_IDLE;
          if (req_we_q) begin
            mem_we           = 1'b1;
            dirty_d[cur_idx] = 1'b1;
          end
        end else begin
          // A store hitting a Branch copy upgrades in place; no victim leaves.
          acq_param_d = !req_we_q ? NTOB : (line_hit ? BTOT : NTOT);
          beat_d      = '0;
          state_d     = (valid_q[cur_idx] && !line_hit) ? S_REL : S_ACQ;
        end
      end
      S_REL, S_PROBE: begin
        bus.tl_c_valid_o   = 1'b1;
        bus.tl_c_opcode_o  = c_opcode;
        bus.tl_c_param_o   = c_param;
        bus.tl_c_size_o    = 4'd6;
        bus.tl_c_address_o = is_probe ? prb_addr_q : victim_addr;
        bus.tl_c_data_o    = c_opcode[0] ? rd_beat : '0;
        if (bus.tl_c_ready_i) begin
          beat_d = beat_q + 3'd1;
          if (c_last) begin
            state_d = is_probe ? S_IDLE : S_REL_ACK;
            if (is_probe && line_hit) begin
              valid_d[cur_idx] = 1'b0;
              dirty_d[cur_idx] = 1'b0;
              perm_d[cur_idx]  = 1'b0;
            end
          end
        end
      end
      S_REL_ACK: begin
        bus.tl_d_ready_o = 1'b1;
        if (bus.tl_d_valid_i) begin
          valid_d[cur_idx] = 1'b0;
          dirty_d[cur_idx] = 1'b0;
          perm_d[cur_idx]  = 1'b0;
          state_d          = S_ACQ;
        end
      end
      S_ACQ: begin
        bus.tl_a_valid_o   = 1'b1;
        bus.tl_a_opcode_o  = A_ACQUIRE_BLOCK;
        bus.tl_a_param_o   = acq_param_q;
        bus.tl_a_size_o    = 4'd6;
        bus.tl_a_address_o = {req_addr_q[63:6], 6'b0};
        bus.tl_a_mask_o    = 8'hFF;
        if (bus.tl_a_ready_i) begin
          beat_d  = '0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        bus.tl_d_ready_o = 1'b1;
        if (bus.tl_d_valid_i) begin
          mem_we    = 1'b1;
          mem_waddr = {cur_idx, beat_q};
          mem_wdata = (req_we_q && beat_q == req_word)
                      ? merge_bytes(bus.tl_d_data_i, req_wdata_q, req_be_q) : bus.tl_d_data_i;
          sink_d    = bus.tl_d_sink_i;
          beat_d    = beat_q + 3'd1;
          if (beat_q == 3'd7) begin
            valid_d[cur_idx] = 1'b1;
            dirty_d[cur_idx] = req_we_q;
            perm_d[cur_idx]  = req_we_q;
            tag_we           = 1'b1;
            state_d          = S_GACK;
          end
        end
      end
      S_GACK: begin
        bus.tl_e_valid_o = 1'b1;
        bus.tl_e_sink_o  = sink_q;
        if (bus.tl_e_ready_i) state_d = S_RESP;
      end
      S_RESP: begin
        bus.rvalid_o = 1'b1;
        bus.rdata_o  = rd_word;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      acq_param_q <= '0;
      sink_q      <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
      perm_q      <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      acq_param_q <= acq_param_d;
      sink_q      <= sink_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      perm_q      <= perm_d;
    end
  end

  // NOTE: data/tag arrays and request latches are not reset; valid bits and the FSM guard them.
  always_ff @(posedge clk_i) begin
    if (mem_we) data_mem[mem_waddr] <= mem_wdata;
    if (tag_we) tag_mem[cur_idx] <= cur_tag;
    if (bus.gnt_o) begin
      req_we_q    <= bus.we_i;
      req_be_q    <= bus.be_i;
      req_addr_q  <= bus.addr_i;
      req_wdata_q <= bus.wdata_i;
    end
    if (bus.tl_b_valid_i && bus.tl_b_ready_o) prb_addr_q <= bus.tl_b_address_i;
  end

  logic unused_inputs;
  assign unused_inputs = ^{bus.tl_b_opcode_i, bus.tl_b_param_i, bus.tl_b_size_i, bus.tl_b_source_i,
                           bus.tl_b_mask_i, bus.tl_b_data_i, bus.tl_b_corrupt_i, bus.tl_d_opcode_i,
                           bus.tl_d_param_i, bus.tl_d_size_i, bus.tl_d_source_i, bus.tl_d_denied_i,
                           bus.tl_d_corrupt_i, req_addr_q[2:0]};
endmodule

// File: tb/tb_l1_dcache_tlc.sv
// Scoreboard bench for l1_dcache_tlc: the bench plays CPU and TL-C manager, queues the
// expected A/C/E/response traffic and a negedge monitor pops and compares it.
module tb_l1_dcache_tlc;
  logic clk = 1'b0;
  logic rst;
  logic inv_all;
  int   cycle = 0;
  int   gnt_cycle = 0;
  int   probe_cycle = 0;
  int   checks = 0;
  int   failures = 0;

  l1_dcache_tlc_if bus ();

  l1_dcache_tlc #(.SETS(64), .SOURCE_ID(4'd0)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .invalidate_all_i (inv_all),
    .bus              (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  typedef struct { logic [2:0] param; logic [63:0] addr; } a_exp_t;
  typedef struct { logic [2:0] op; logic [2:0] param; logic [63:0] addr; bit has_data; logic [63:0] data; } c_exp_t;
  typedef struct { bit chk; logic [63:0] data; int lat; } r_exp_t;

  a_exp_t     a_q[$];
  c_exp_t     c_q[$];
  logic [3:0] e_q[$];
  r_exp_t     r_q[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Ready signals wander so handshakes get stalled at random points.
  always @(posedge clk) begin
    #1;
    bus.tl_a_ready_i = !rst && ($urandom_range(0, 3) != 0);
    bus.tl_c_ready_i = !rst && ($urandom_range(0, 2) != 0);
    bus.tl_e_ready_i = !rst && ($urandom_range(0, 1) != 0);
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.tl_a_valid_o && bus.tl_a_ready_i) begin
        if (a_q.size() == 0) check("a_unexpected", 1, 0);
        else begin
          a_exp_t a;
          a = a_q.pop_front();
          check("a_opcode", bus.tl_a_opcode_o, 6);
          check("a_param", bus.tl_a_param_o, a.param);
          check("a_address", bus.tl_a_address_o, a.addr);
          check("a_size", bus.tl_a_size_o, 6);
          check("a_mask", bus.tl_a_mask_o, 8'hFF);
          check("a_source", bus.tl_a_source_o, 0);
        end
      end
      if (bus.tl_c_valid_o && bus.tl_c_ready_i) begin
        if (c_q.size() == 0) check("c_unexpected", 1, 0);
        else begin
          c_exp_t c;
          c = c_q.pop_front();
          check("c_opcode", bus.tl_c_opcode_o, c.op);
          check("c_param", bus.tl_c_param_o, c.param);
          check("c_address", bus.tl_c_address_o, c.addr);
          check("c_source", bus.tl_c_source_o, 0);
          if (c.has_data) check("c_data", bus.tl_c_data_o, c.data);
        end
      end
      if (bus.tl_e_valid_o && bus.tl_e_ready_i) begin
        if (e_q.size() == 0) check("e_unexpected", 1, 0);
        else check("e_sink", bus.tl_e_sink_o, e_q.pop_front());
      end
      if (bus.rvalid_o) begin
        if (r_q.size() == 0) check("rvalid_unexpected", 1, 0);
        else begin
          r_exp_t r;
          r = r_q.pop_front();
          if (r.chk) check("rdata", bus.rdata_o, r.data);
          if (r.lat >= 0) check("r_latency", cycle - gnt_cycle, r.lat);
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [2:0] param, input logic [63:0] addr);
    a_exp_t a;
    a.param = param;
    a.addr  = addr;
    a_q.push_back(a);
  endtask

  task automatic push_c(input logic [2:0] op, input logic [2:0] param, input logic [63:0] addr,
                        input bit has_data, input logic [63:0] data);
    c_exp_t c;
    c.op = op; c.param = param; c.addr = addr; c.has_data = has_data; c.data = data;
    c_q.push_back(c);
  endtask

  task automatic push_r(input bit chk, input logic [63:0] data, input int lat);
    r_exp_t r;
    r.chk = chk; r.data = data; r.lat = lat;
    r_q.push_back(r);
  endtask

  function automatic int qsize(input int sel);
    case (sel)
      0: return a_q.size();
      1: return c_q.size();
      2: return e_q.size();
      default: return r_q.size();
    endcase
  endfunction

  task automatic wait_drain(input string tag, input int sel);
    for (int i = 0; i < 400; i++) begin
      if (qsize(sel) == 0) break;
      @(negedge clk);
    end
    check(tag, qsize(sel), 0);
  endtask

  task automatic cpu_req(input bit we, input logic [7:0] be, input logic [63:0] addr,
                         input logic [63:0] wdata);
    bit got = 0;
    sync();
    bus.req_i = 1'b1; bus.we_i = we; bus.be_i = be; bus.addr_i = addr; bus.wdata_i = wdata;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.gnt_o) begin
        got = 1;
        gnt_cycle = cycle;
        break;
      end
    end
    check("gnt", got, 1);
    sync();
    bus.req_i = 1'b0;
  endtask

  task automatic probe(input logic [63:0] addr);
    bit got = 0;
    sync();
    bus.tl_b_valid_i = 1'b1; bus.tl_b_opcode_i = 3'd6; bus.tl_b_param_i = 3'd1;
    bus.tl_b_size_i = 4'd6; bus.tl_b_address_i = addr; bus.tl_b_mask_i = 8'hFF;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.tl_b_ready_o) begin
        got = 1;
        probe_cycle = cycle;
        break;
      end
    end
    check("b_ready", got, 1);
    sync();
    bus.tl_b_valid_i = 1'b0;
  endtask

  task automatic d_send(input logic [2:0] op, input logic [63:0] data, input logic [3:0] sink);
    bit got = 0;
    sync();
    bus.tl_d_valid_i = 1'b1; bus.tl_d_opcode_i = op; bus.tl_d_data_i = data;
    bus.tl_d_sink_i = sink; bus.tl_d_size_i = 4'd6;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.tl_d_ready_o) begin
        got = 1;
        break;
      end
    end
    check("d_ready", got, 1);
    sync();
    bus.tl_d_valid_i = 1'b0;
  endtask

  // A miss: optional victim Release answered by ReleaseAck, then Acquire/Grant/GrantAck/response.
  task automatic miss(input bit we, input logic [7:0] be, input logic [63:0] addr,
                      input logic [63:0] wdata, input logic [2:0] param, input bit with_release,
                      input logic [63:0] base, input logic [3:0] sink, input bit chk,
                      input logic [63:0] exp_data);
    push_a(param, {addr[63:6], 6'b0});
    e_q.push_back(sink);
    push_r(chk, exp_data, -1);
    cpu_req(we, be, addr, wdata);
    if (with_release) begin
      wait_drain("release_done", 1);
      check("acquire_after_release_ack", a_q.size(), 1);
      d_send(3'd6, 64'd0, 4'd0);
    end
    wait_drain("acquire_done", 0);
    for (int k = 0; k < 8; k++) d_send(3'd5, base + 64'(k), sink);
    wait_drain("grant_ack_done", 2);
    wait_drain("miss_response", 3);
  endtask

  task automatic hit(input bit we, input logic [7:0] be, input logic [63:0] addr,
                     input logic [63:0] wdata, input bit chk, input logic [63:0] exp_data);
    push_r(chk, exp_data, 1);
    cpu_req(we, be, addr, wdata);
    wait_drain("hit_response", 3);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; inv_all = 1'b0;
    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.be_i = '0; bus.addr_i = '0; bus.wdata_i = '0;
    bus.tl_a_ready_i = 1'b0; bus.tl_c_ready_i = 1'b0; bus.tl_e_ready_i = 1'b0;
    bus.tl_b_valid_i = 1'b1; bus.tl_b_opcode_i = '0; bus.tl_b_param_i = '0; bus.tl_b_size_i = '0;
    bus.tl_b_source_i = '0; bus.tl_b_address_i = '0; bus.tl_b_mask_i = '0; bus.tl_b_data_i = '0;
    bus.tl_b_corrupt_i = 1'b0;
    bus.tl_d_valid_i = 1'b0; bus.tl_d_opcode_i = '0; bus.tl_d_param_i = '0; bus.tl_d_size_i = '0;
    bus.tl_d_source_i = '0; bus.tl_d_sink_i = '0; bus.tl_d_denied_i = 1'b0; bus.tl_d_data_i = '0;
    bus.tl_d_corrupt_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", bus.gnt_o, 0);
    check("rst_rvalid", bus.rvalid_o, 0);
    check("rst_rdata", bus.rdata_o, 0);
    check("rst_a_valid", bus.tl_a_valid_o, 0);
    check("rst_b_ready", bus.tl_b_ready_o, 0);
    check("rst_c_valid", bus.tl_c_valid_o, 0);
    check("rst_d_ready", bus.tl_d_ready_o, 0);
    check("rst_e_valid", bus.tl_e_valid_o, 0);
    check("rst_c_data", bus.tl_c_data_o, 0);
    check("rst_corrupt", {bus.tl_a_corrupt_o, bus.tl_c_corrupt_o}, 0);
    sync();
    rst = 1'b0; bus.req_i = 1'b0; bus.tl_b_valid_i = 1'b0;
    @(negedge clk);
    check("idle_b_ready", bus.tl_b_ready_o, 1);

    // Store miss 0x1000: NtoT acquire, data 0..7, sink 1.
    miss(1, 8'hFF, 64'h1000, 64'hDEADBEEF, 3'd1, 0, 64'd0, 4'd1, 0, 64'd0);

    // Probe the dirty line: ProbeAckData TtoN with the merged store in beat 0.
    push_c(3'd5, 3'd1, 64'h1000, 1, 64'hDEADBEEF);
    for (int k = 1; k < 8; k++) push_c(3'd5, 3'd1, 64'h1000, 1, 64'(k));
    probe(64'h1000);
    wait_drain("probe_dirty_done", 1);

    // Line was invalidated by the probe: load misses with NtoB.
    miss(0, 8'hFF, 64'h1000, 64'd0, 3'd0, 0, 64'd0, 4'd2, 1, 64'd0);
    hit(0, 8'hFF, 64'h1008, 64'd0, 1, 64'd1);

    // Store to a Branch copy upgrades with BtoT, then a store hit on the Trunk copy.
    miss(1, 8'h0F, 64'h1010, 64'hFFFF_FFFF_1234_5678, 3'd2, 0, 64'd0, 4'd3, 0, 64'd0);
    hit(1, 8'hFF, 64'h1018, 64'hA5A5_A5A5_A5A5_A5A5, 0, 64'd0);
    hit(0, 8'hFF, 64'h1010, 64'd0, 1, 64'h1234_5678);

    // Conflict miss one way-size above: dirty victim leaves as ReleaseData first.
    for (int k = 0; k < 8; k++) begin
      logic [63:0] d;
      d = (k == 2) ? 64'h1234_5678 : (k == 3) ? 64'hA5A5_A5A5_A5A5_A5A5 : 64'(k);
      push_c(3'd7, 3'd1, 64'h1000, 1, d);
    end
    miss(0, 8'hFF, 64'h1000 + 64 * 64, 64'd0, 3'd0, 1, 64'h100, 4'd4, 1, 64'h100);

    // Clean Branch victim: single-beat Release BtoN.
    push_c(3'd6, 3'd2, 64'h2000, 0, 64'd0);
    miss(0, 8'hFF, 64'h3038, 64'd0, 3'd0, 1, 64'h200, 4'd5, 1, 64'h207);

    // Probe to an absent line raised together with a CPU hit: probe wins.
    push_c(3'd4, 3'd5, 64'h5000, 0, 64'd0);
    push_r(1, 64'h200, 1);
    fork
      probe(64'h5000);
      cpu_req(0, 8'hFF, 64'h3000, 64'd0);
    join
    wait_drain("probe_absent_done", 1);
    wait_drain("hit_after_probe", 3);
    check("probe_before_gnt", probe_cycle < gnt_cycle, 1);

    // Probe of a clean Branch line, then invalidate_all drops a refilled line.
    push_c(3'd4, 3'd2, 64'h3000, 0, 64'd0);
    probe(64'h3000);
    wait_drain("probe_clean_done", 1);
    miss(0, 8'hFF, 64'h3000, 64'd0, 3'd0, 0, 64'h300, 4'd6, 1, 64'h300);
    sync();
    inv_all = 1'b1;
    sync();
    inv_all = 1'b0;
    miss(0, 8'hFF, 64'h3008, 64'd0, 3'd0, 0, 64'h400, 4'd7, 1, 64'h401);

    repeat (5) @(negedge clk);
    check("a_queue_empty", a_q.size(), 0);
    check("c_queue_empty", c_q.size(), 0);
    check("e_queue_empty", e_q.size(), 0);
    check("r_queue_empty", r_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
